button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Turns raw push-button inputs into clean single-cycle "blips" on Clk100M for the GamePlay user count inputs (userUp/userDown).
//   Per button: 2-FF synchroniser, debounce of both edges, one blip per press, optional auto-repeat while held.
//   Sits between the board pins and GamePlay; enable gates blips to the counting window.
// PARAMETERS
//   NUM_BTN          2           number of independent buttons (bit 0 = up, bit 1 = down)
//   DEBOUNCE_CYCLES  1000000     cycles the input must be stable to accept an edge (10 ms @100 MHz), >=1
//   REPEAT_EN        1           1 = auto-repeat while held, 0 = one blip per press
//   REPEAT_DELAY     50000000    held cycles after the press blip before the first repeat blip, >=1
//   REPEAT_PERIOD    10000000    cycles between subsequent repeat blips, >=1
//   MUTEX            1           1 = drop all blips in a cycle where more than one button blips
//   CNT_W            26          counter width, must hold max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)-1
// PORTS
//   Clk100M  in   1        system clock
//   reset    in   1        synchronous, active-low reset
//   enable   in   1        1 = blips may be emitted; 0 = events are dropped (FSM keeps tracking)
//   btnRaw   in   NUM_BTN  raw asynchronous button levels, 1 = pressed
//   blip     out  NUM_BTN  registered, 1-cycle press/repeat pulses
//   level    out  NUM_BTN  registered debounced button state
// BEHAVIOUR
//   Reset (reset==0 at an edge): sync flops, counters, blip, level all 0; every FSM -> RELEASED.
//   Synchroniser: btnRaw -> s1 -> s2; the FSM sees only s2.
//   Per-button FSM, counter cnt (CNT_W bits, cleared on every state change):
//     RELEASED   : s2==1 -> PRESS_DB
//     PRESS_DB   : s2==0 -> RELEASED (bounce, no event); cnt==DEBOUNCE_CYCLES-1 -> HELD, press event, level<=1; else cnt++
//     HELD       : s2==0 -> RELEASE_DB; REPEAT_EN && cnt==REPEAT_DELAY-1 -> REPEAT, repeat event; else cnt++
//     REPEAT     : s2==0 -> RELEASE_DB; cnt==REPEAT_PERIOD-1 -> repeat event, cnt<=0; else cnt++
//     RELEASE_DB : s2==1 -> HELD (bounce, no event, repeat timing restarts);
//                  cnt==DEBOUNCE_CYCLES-1 -> RELEASED, level<=0; else cnt++
//   Latency: edge 0 = first edge sampling btnRaw=1 (held clean).
//     blip high for exactly one cycle after edge 2+DEBOUNCE_CYCLES; level rises on the same edge.
//     First repeat REPEAT_DELAY edges after the press blip, then every REPEAT_PERIOD edges.
//     level falls 2+DEBOUNCE_CYCLES edges after a clean release.
//   Emission: blip[i] <= event[i] & enable & ~(MUTEX & (>1 events this cycle)).
//     Dropped events are lost, never queued; the FSM advances regardless.
//   enable toggling mid-hold does not restart timing; the next scheduled repeat is emitted if enable=1 at that edge.
//   Reset mid-press: a button still held afterwards re-debounces from RELEASED and yields exactly one press blip.
//   Counters never wrap: every compare terminates counting before CNT_W overflow.
// STRUCTURE
//   Shared package (game_pkg): FSM state encoding (RELEASED, PRESS_DB, HELD, REPEAT, RELEASE_DB), 3-bit state width,
//     default timing constants at 100 MHz.
//   Sub-module btn_debounce_fsm: one button (sync, FSM, cnt; outputs event, level), instantiated NUM_BTN times via generate.
//   Top: MUTEX/enable gating and the blip output register.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, enable=1 unless stated)
//   Clean press of btn0 held 8 cycles, REPEAT_EN=0 -> blip[0] one cycle after edge 6, level[0] 1 from edge 6, no further blips.
//   btn0 bounces 1,0,1,0 then steady 1 -> exactly one blip[0], 2+4 edges after the steady 1 begins; no blip during the bounce.
//   btn0 held 30 cycles, REPEAT_EN=1 -> blips at edges 6, 16, 19, 22, 25, 28, 31; none after release;
//     level[0] falls 6 edges after release.
//   btn0 and btn1 pressed on the same cycle, MUTEX=1 -> no blips at edge 6; with MUTEX=0 -> both blip at edge 6.
//   enable=0 during the press edge, then enable=1 while held, REPEAT_EN=0 -> no blip at all (event dropped).
//   reset asserted for 1 cycle at edge 8 while btn0 held -> blip, level cleared; new single blip at edge 8+1+6; no blip during reset.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-button FSM state encoding
// and default timing constants for a 100 MHz system clock.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RELEASED   = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } btn_state_t;

  localparam int DEF_NUM_BTN         = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;
  localparam int DEF_MUTEX           = 1;
  localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/button_conditioner_if.sv
// Board-side bundle of the button conditioner: enable and raw levels in,
// press/repeat blips and debounced levels out.
interface button_conditioner_if #(
  parameter int NUM_BTN = 2
);
  logic               enable;
  logic [NUM_BTN-1:0] btnRaw;
  logic [NUM_BTN-1:0] blip;
  logic [NUM_BTN-1:0] level;

  modport master (
    output enable,
    output btnRaw,
    input  blip,
    input  level
  );

  modport slave (
    input  enable,
    input  btnRaw,
    output blip,
    output level
  );
endinterface

// File: rtl/button_conditioner_fsm.sv
// One button: 2-FF synchroniser, debounce of both edges and auto-repeat timing.
// evt is combinational and marks the cycle a press or repeat is accepted.
module btn_debounce_fsm
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic evt,
  output logic level
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1;
  logic             s2;
  btn_state_t       state;
  btn_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

  // Every state change clears cnt; a release always wins over a pending repeat.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    evt        = 1'b0;
    case (state)
      RELEASED: begin
        if (s2) begin
          state_next = PRESS_DB;
          cnt_next   = '0;
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          evt        = 1'b1;
          level_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_next = RELEASE_DB;
          cnt_next   = '0;
        end else if (REPEAT_EN != 0) begin
          if (cnt == DELAY_LAST) begin
            state_next = REPEAT;
            cnt_next   = '0;
            evt        = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_next = RELEASE_DB;
          cnt_next   = '0;
        end else if (cnt == PERIOD_LAST) begin
          cnt_next = '0;
          evt      = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RELEASE_DB: begin
        if (s2) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw push-buttons into registered single-cycle blips,
// gated by enable and optionally suppressed when buttons blip together.
module button_conditioner
  import game_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int MUTEX           = DEF_MUTEX,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic                 Clk100M,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] blip_q;
  logic               multi;
  logic               drop;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_fsm (
      .clk   (Clk100M),
      .reset (reset),
      .raw   (bus.btnRaw[i]),
      .evt   (evt[i]),
      .level (lvl[i])
    );
  end

  // Clearing the lowest set bit leaves something only if two or more events fired.
  assign multi = (evt & (evt - NUM_BTN'(1))) != '0;
  assign drop  = (MUTEX != 0) && multi;

  always_ff @(posedge Clk100M) begin
    if (!reset) begin
      blip_q <= '0;
    end else begin
      blip_q <= evt & {NUM_BTN{bus.enable}} & ~{NUM_BTN{drop}};
    end
  end

  assign bus.blip  = blip_q;
  assign bus.level = lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, delay 10, period 3);
// three instances cover repeat off/on and mutex on/off under shared stimulus.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] btn;
  int         vec_count = 0;
  int         miss_count = 0;

  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_BTN(2)) if_a ();
  button_conditioner_if #(.NUM_BTN(2)) if_b ();
  button_conditioner_if #(.NUM_BTN(2)) if_c ();

  assign if_a.enable = en;
  assign if_a.btnRaw = btn;
  assign if_b.enable = en;
  assign if_b.btnRaw = btn;
  assign if_c.enable = en;
  assign if_c.btnRaw = btn;

  // a: no repeat, mutex on; b: repeat, mutex on; c: no repeat, mutex off
  button_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .MUTEX(1), .CNT_W(8)
  ) u_a (.Clk100M(clk), .reset(reset), .bus(if_a));

  button_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .MUTEX(1), .CNT_W(8)
  ) u_b (.Clk100M(clk), .reset(reset), .bus(if_b));

  button_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .MUTEX(0), .CNT_W(8)
  ) u_c (.Clk100M(clk), .reset(reset), .bus(if_c));

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] b, input logic e);
    btn = b;
    en  = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    applyStimulus(2'b00, 1'b1);
    repeat (16) tick();
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(2'b00, 1'b1);
    repeat (3) tick();
    checkOutput("rst blip a", if_a.blip, 2'b00);
    checkOutput("rst level a", if_a.level, 2'b00);
    checkOutput("rst blip b", if_b.blip, 2'b00);
    checkOutput("rst level b", if_b.level, 2'b00);
    checkOutput("rst blip c", if_c.blip, 2'b00);
    checkOutput("rst level c", if_c.level, 2'b00);
    reset = 1'b1;
    repeat (3) tick();

    // Edge e below is the e-th posedge after the stimulus change.
    applyStimulus(2'b01, 1'b1);
    for (int e = 0; e <= 20; e++) begin
      tick();
      checkOutput($sformatf("t1 blip e%0d", e), if_a.blip, (e == 6) ? 2'b01 : 2'b00);
      checkOutput($sformatf("t1 level e%0d", e), if_a.level,
                  (e >= 6 && e < 14) ? 2'b01 : 2'b00);
      if (e == 7) applyStimulus(2'b00, 1'b1);
    end
    settle();

    applyStimulus(2'b01, 1'b1);
    for (int e = 0; e <= 24; e++) begin
      tick();
      checkOutput($sformatf("t2 blip e%0d", e), if_a.blip, (e == 10) ? 2'b01 : 2'b00);
      checkOutput($sformatf("t2 level e%0d", e), if_a.level,
                  (e >= 10 && e < 21) ? 2'b01 : 2'b00);
      if (e == 0 || e == 2) applyStimulus(2'b00, 1'b1);
      if (e == 1 || e == 3) applyStimulus(2'b01, 1'b1);
      if (e == 14) applyStimulus(2'b00, 1'b1);
    end
    settle();

    applyStimulus(2'b01, 1'b1);
    for (int e = 0; e <= 40; e++) begin
      tick();
      checkOutput($sformatf("t3 blip e%0d", e), if_b.blip,
                  (e inside {6, 16, 19, 22, 25, 28, 31}) ? 2'b01 : 2'b00);
      checkOutput($sformatf("t3 level e%0d", e), if_b.level,
                  (e >= 6 && e < 36) ? 2'b01 : 2'b00);
      if (e == 29) applyStimulus(2'b00, 1'b1);
    end
    settle();

    applyStimulus(2'b11, 1'b1);
    for (int e = 0; e <= 20; e++) begin
      tick();
      checkOutput($sformatf("t4 mutex blip e%0d", e), if_a.blip, 2'b00);
      checkOutput($sformatf("t4 nomutex blip e%0d", e), if_c.blip,
                  (e == 6) ? 2'b11 : 2'b00);
      checkOutput($sformatf("t4 level e%0d", e), if_a.level,
                  (e >= 6 && e < 14) ? 2'b11 : 2'b00);
      if (e == 7) applyStimulus(2'b00, 1'b1);
    end
    settle();

    applyStimulus(2'b01, 1'b0);
    for (int e = 0; e <= 20; e++) begin
      tick();
      checkOutput($sformatf("t5 blip e%0d", e), if_a.blip, 2'b00);
      checkOutput($sformatf("t5 level e%0d", e), if_a.level,
                  (e >= 6 && e < 18) ? 2'b01 : 2'b00);
      if (e == 7) applyStimulus(2'b01, 1'b1);
      if (e == 11) applyStimulus(2'b00, 1'b1);
    end
    settle();

    applyStimulus(2'b01, 1'b1);
    for (int e = 0; e <= 22; e++) begin
      tick();
      checkOutput($sformatf("t6 blip e%0d", e), if_a.blip,
                  (e == 6 || e == 15) ? 2'b01 : 2'b00);
      checkOutput($sformatf("t6 level e%0d", e), if_a.level,
                  (e == 6 || e == 7 || e >= 15) ? 2'b01 : 2'b00);
      if (e == 7) reset = 1'b0;
      if (e == 8) reset = 1'b1;
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
